// File: rtl/memory_access_if.sv
// Data-memory bus between the M-stage (master) and data memory (slave).
// valid/grant request phase followed by an rvalid read-data phase.
interface memory_access_if;
    logic        dmem_o_req;
    logic        dmem_o_we;
    logic [31:0] dmem_o_addr;
    logic [31:0] dmem_o_wdata;
    logic [3:0]  dmem_o_wstrb;
    logic        dmem_i_gnt;
    logic        dmem_i_rvalid;
    logic [31:0] dmem_i_rdata;

    modport master (
        output dmem_o_req, dmem_o_we, dmem_o_addr, dmem_o_wdata, dmem_o_wstrb,
        input  dmem_i_gnt, dmem_i_rvalid, dmem_i_rdata
    );

    modport slave (
        input  dmem_o_req, dmem_o_we, dmem_o_addr, dmem_o_wdata, dmem_o_wstrb,
        output dmem_i_gnt, dmem_i_rvalid, dmem_i_rdata
    );
endinterface

// File: rtl/memory_access.sv
// Pipeline M-stage: runs load/store transactions on the data-memory bus,
// aligns/extends load data and stalls upstream while a transaction is open.
module memory_access #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regM_i_valid,
    input  logic [31:0] regM_i_valE,
    input  logic [31:0] regM_i_valB,
    input  logic        regM_i_mem_rd,
    input  logic        regM_i_mem_wr,
    input  logic [1:0]  regM_i_mem_size,
    input  logic        regM_i_mem_unsigned,
    output logic [31:0] memory_o_valM,
    output logic        memory_o_valid,
    output logic        memory_o_stall,
    output logic        memory_o_misalign,
    output logic        memory_o_fault,
    memory_access_if.master dmem
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] valm_q, valm_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic        is_byte, is_half, is_word, misal, rw, memop, tmo_hit;
    logic [1:0]  off;
    logic [3:0]  strb_n;
    logic [31:0] wdata_n, shifted, ld_data;

    assign off     = regM_i_valE[1:0];
    assign is_byte = (regM_i_mem_size == 2'b00);
    assign is_half = (regM_i_mem_size == 2'b01);
    assign is_word = regM_i_mem_size[1];
    assign misal   = (is_half && off[0]) || (is_word && (off != 2'b00));
    assign rw      = regM_i_mem_rd || regM_i_mem_wr;
    assign memop   = regM_i_valid && rw && !misal;
    assign tmo_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT));

    // Store lane placement
    always_comb begin
        strb_n  = 4'b1111;
        wdata_n = regM_i_valB;
        if (is_byte) begin
            strb_n  = 4'b0001 << off;
            wdata_n = {4{regM_i_valB[7:0]}};
        end else if (is_half) begin
            strb_n  = 4'b0011 << off;
            wdata_n = {2{regM_i_valB[15:0]}};
        end
    end

    // Load extraction uses the offset/size captured at issue
    assign shifted = dmem.dmem_i_rdata >> {off_q, 3'b000};
    always_comb begin
        ld_data = dmem.dmem_i_rdata;
        if (size_q == 2'b00)
            ld_data = {{24{!uns_q && shifted[7]}}, shifted[7:0]};
        else if (size_q == 2'b01)
            ld_data = {{16{!uns_q && shifted[15]}}, shifted[15:0]};
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        valm_d  = valm_q;
        cnt_d   = cnt_q;
        fault_d = 1'b0;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = regM_i_mem_wr;
                    addr_d  = {regM_i_valE[31:2], 2'b00};
                    wdata_d = wdata_n;
                    wstrb_d = regM_i_mem_wr ? strb_n : 4'b0000;
                    valm_d  = 32'd0;
                    cnt_d   = 32'd0;
                    off_d   = off;
                    size_d  = regM_i_mem_size;
                    uns_d   = regM_i_mem_unsigned;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (dmem.dmem_i_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        valm_d  = regM_i_valE;
                        state_d = DONE;
                    end else if (dmem.dmem_i_rvalid) begin
                        valm_d  = ld_data;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (tmo_hit) begin
                    req_d   = 1'b0;
                    valm_d  = 32'd0;
                    fault_d = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (dmem.dmem_i_rvalid) begin
                    valm_d  = ld_data;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    valm_d  = 32'd0;
                    fault_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            valm_q  <= 32'd0;
            cnt_q   <= 32'd0;
            fault_q <= 1'b0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            valm_q  <= valm_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    assign dmem.dmem_o_req   = req_q;
    assign dmem.dmem_o_we    = we_q;
    assign dmem.dmem_o_addr  = addr_q;
    assign dmem.dmem_o_wdata = wdata_q;
    assign dmem.dmem_o_wstrb = wstrb_q;

    // Non-memory and misaligned instructions complete in IDLE with zero latency
    assign memory_o_stall    = memop && (state_q != DONE);
    assign memory_o_misalign = (state_q == IDLE) && regM_i_valid && rw && misal;
    assign memory_o_valid    = (state_q == DONE) ||
                               ((state_q == IDLE) && regM_i_valid && !memop);
    assign memory_o_valM     = (state_q == DONE) ? valm_q : regM_i_valE;
    assign memory_o_fault    = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access (TIMEOUT=8): pass-through, loads, stores,
// misalign, same-cycle gnt/rvalid, timeout fault and reset mid-transaction.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        regM_i_valid;
    logic [31:0] regM_i_valE;
    logic [31:0] regM_i_valB;
    logic        regM_i_mem_rd;
    logic        regM_i_mem_wr;
    logic [1:0]  regM_i_mem_size;
    logic        regM_i_mem_unsigned;
    logic [31:0] memory_o_valM;
    logic        memory_o_valid;
    logic        memory_o_stall;
    logic        memory_o_misalign;
    logic        memory_o_fault;

    int total = 0;
    int bad   = 0;

    memory_access_if bus();

    memory_access #(.TIMEOUT(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .regM_i_valid        (regM_i_valid),
        .regM_i_valE         (regM_i_valE),
        .regM_i_valB         (regM_i_valB),
        .regM_i_mem_rd       (regM_i_mem_rd),
        .regM_i_mem_wr       (regM_i_mem_wr),
        .regM_i_mem_size     (regM_i_mem_size),
        .regM_i_mem_unsigned (regM_i_mem_unsigned),
        .memory_o_valM       (memory_o_valM),
        .memory_o_valid      (memory_o_valid),
        .memory_o_stall      (memory_o_stall),
        .memory_o_misalign   (memory_o_misalign),
        .memory_o_fault      (memory_o_fault),
        .dmem                (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle: drive just after posedge
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [31:0] e, input logic [31:0] b,
                      input logic rd, input logic wr, input logic [1:0] sz, input logic u);
        regM_i_valid        = v;
        regM_i_valE         = e;
        regM_i_valB         = b;
        regM_i_mem_rd       = rd;
        regM_i_mem_wr       = wr;
        regM_i_mem_size     = sz;
        regM_i_mem_unsigned = u;
    endtask

    task automatic bus_in(input logic g, input logic rv, input logic [31:0] rd);
        bus.dmem_i_gnt    = g;
        bus.dmem_i_rvalid = rv;
        bus.dmem_i_rdata  = rd;
    endtask

    initial begin
        rst = 1'b1;
        op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        bus_in(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("rst_req",   32'(bus.dmem_o_req), 32'd0);
        chk("rst_addr",  bus.dmem_o_addr, 32'd0);
        chk("rst_wstrb", 32'(bus.dmem_o_wstrb), 32'd0);
        chk("rst_fault", 32'(memory_o_fault), 32'd0);
        chk("rst_valid", 32'(memory_o_valid), 32'd0);
        go();
        rst = 1'b0;

        // ADD pass-through
        op(1'b1, 32'h1234, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        chk("add_valM",  memory_o_valM, 32'h1234);
        chk("add_valid", 32'(memory_o_valid), 32'd1);
        chk("add_stall", 32'(memory_o_stall), 32'd0);
        go();
        @(negedge clk);
        chk("add_noreq", 32'(bus.dmem_o_req), 32'd0);

        // LB 0x103: gnt cycle 1, rvalid cycle 2, valid cycle 3
        go();
        op(1'b1, 32'h103, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        chk("lb_c0_stall", 32'(memory_o_stall), 32'd1);
        chk("lb_c0_valid", 32'(memory_o_valid), 32'd0);
        go();
        bus_in(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        chk("lb_c1_req",   32'(bus.dmem_o_req), 32'd1);
        chk("lb_c1_addr",  bus.dmem_o_addr, 32'h100);
        chk("lb_c1_we",    32'(bus.dmem_o_we), 32'd0);
        chk("lb_c1_stall", 32'(memory_o_stall), 32'd1);
        go();
        bus_in(1'b0, 1'b1, 32'h80FF_FF7F);
        @(negedge clk);
        chk("lb_c2_req",   32'(bus.dmem_o_req), 32'd0);
        chk("lb_c2_stall", 32'(memory_o_stall), 32'd1);
        chk("lb_c2_valid", 32'(memory_o_valid), 32'd0);
        go();
        bus_in(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("lb_c3_valid", 32'(memory_o_valid), 32'd1);
        chk("lb_c3_valM",  memory_o_valM, 32'hFFFF_FF80);
        chk("lb_c3_stall", 32'(memory_o_stall), 32'd0);

        // SH 0x202, gnt held low 4 cycles
        go();
        op(1'b1, 32'h202, 32'hABCD_1234, 1'b0, 1'b1, 2'b01, 1'b0);
        @(negedge clk);
        chk("sh_c0_stall", 32'(memory_o_stall), 32'd1);
        for (int i = 0; i < 5; i++) begin
            go();
            if (i == 4) bus_in(1'b1, 1'b0, 32'd0);
            @(negedge clk);
            chk($sformatf("sh_req%0d", i),   32'(bus.dmem_o_req), 32'd1);
            chk($sformatf("sh_addr%0d", i),  bus.dmem_o_addr, 32'h200);
            chk($sformatf("sh_strb%0d", i),  32'(bus.dmem_o_wstrb), 32'hC);
            chk($sformatf("sh_wdata%0d", i), bus.dmem_o_wdata, 32'h1234_1234);
            chk($sformatf("sh_we%0d", i),    32'(bus.dmem_o_we), 32'd1);
        end
        go();
        bus_in(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("sh_done_valid", 32'(memory_o_valid), 32'd1);
        chk("sh_done_stall", 32'(memory_o_stall), 32'd0);
        chk("sh_done_valM",  memory_o_valM, 32'h202);
        chk("sh_done_req",   32'(bus.dmem_o_req), 32'd0);

        // LW 0x102 misaligned
        go();
        op(1'b1, 32'h102, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        chk("lw_mis",       32'(memory_o_misalign), 32'd1);
        chk("lw_mis_valid", 32'(memory_o_valid), 32'd1);
        chk("lw_mis_stall", 32'(memory_o_stall), 32'd0);
        chk("lw_mis_valM",  memory_o_valM, 32'h102);
        go();
        @(negedge clk);
        chk("lw_mis_noreq", 32'(bus.dmem_o_req), 32'd0);

        // LHU 0x0, gnt and rvalid in the same cycle
        go();
        op(1'b1, 32'h0, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1);
        @(negedge clk);
        chk("lhu_c0_mis", 32'(memory_o_misalign), 32'd0);
        go();
        bus_in(1'b1, 1'b1, 32'h0000_F00D);
        @(negedge clk);
        chk("lhu_c1_req", 32'(bus.dmem_o_req), 32'd1);
        go();
        bus_in(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("lhu_c2_valid", 32'(memory_o_valid), 32'd1);
        chk("lhu_c2_valM",  memory_o_valM, 32'h0000_F00D);

        // LH 0x2 signed: upper half of rdata
        go();
        op(1'b1, 32'h2, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0);
        go();
        bus_in(1'b1, 1'b1, 32'h8001_7777);
        go();
        bus_in(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("lh_valM", memory_o_valM, 32'hFFFF_8001);

        // SB 0x301
        go();
        op(1'b1, 32'h301, 32'h1122_3355, 1'b0, 1'b1, 2'b00, 1'b0);
        go();
        bus_in(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        chk("sb_strb",  32'(bus.dmem_o_wstrb), 32'h2);
        chk("sb_wdata", bus.dmem_o_wdata, 32'h5555_5555);
        go();
        bus_in(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("sb_valid", 32'(memory_o_valid), 32'd1);

        // Timeout: LW 0x400, never granted; REQ cycles 1..8, fault in cycle 9
        go();
        op(1'b1, 32'h400, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            go();
            @(negedge clk);
            chk($sformatf("to_req%0d", i),   32'(bus.dmem_o_req), 32'd1);
            chk($sformatf("to_fault%0d", i), 32'(memory_o_fault), 32'd0);
            chk($sformatf("to_valid%0d", i), 32'(memory_o_valid), 32'd0);
        end
        go();
        @(negedge clk);
        chk("to_fault", 32'(memory_o_fault), 32'd1);
        chk("to_valM",  memory_o_valM, 32'd0);
        chk("to_valid", 32'(memory_o_valid), 32'd1);
        chk("to_req",   32'(bus.dmem_o_req), 32'd0);
        chk("to_stall", 32'(memory_o_stall), 32'd0);
        go();
        op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        chk("to_pulse_end", 32'(memory_o_fault), 32'd0);

        // Reset during WAIT of a new load, then a stray rvalid
        go();
        op(1'b1, 32'h500, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        go();
        bus_in(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        chk("rw_c1_req", 32'(bus.dmem_o_req), 32'd1);
        go();
        bus_in(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("rw_wait_stall", 32'(memory_o_stall), 32'd1);
        #2;
        rst = 1'b1;
        regM_i_valid = 1'b0;
        #1;
        chk("rw_rst_req",   32'(bus.dmem_o_req), 32'd0);
        chk("rw_rst_valid", 32'(memory_o_valid), 32'd0);
        chk("rw_rst_stall", 32'(memory_o_stall), 32'd0);
        go();
        rst = 1'b0;
        bus_in(1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rw_late_valid", 32'(memory_o_valid), 32'd0);
        go();
        bus_in(1'b0, 1'b0, 32'd0);
        op(1'b1, 32'h77, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        chk("rw_after_valM",  memory_o_valM, 32'h77);
        chk("rw_after_valid", 32'(memory_o_valid), 32'd1);
        chk("rw_after_req",   32'(bus.dmem_o_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
